// File: rtl/bus_pkg.sv
// Shared coherence-bus types: L2 state encoding, transfer width
// and the power-on memory pattern helper.
package bus_pkg;

  localparam int BLOCK_SIZE = 2;
  localparam int DATA_WIDTH = 32 * BLOCK_SIZE;

  typedef logic [31:0] word_t;
  typedef logic [DATA_WIDTH-1:0] transfer_width_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'b00,
    L2_BUSY   = 2'b01,
    L2_ACCESS = 2'b10,
    L2_ERROR  = 2'b11
  } l2_state_t;

  // Each word of the reset image holds its own byte address.
  function automatic word_t pattern_word(
    input word_t base,
    input int    blk,
    input int    wrd,
    input int    blk_bytes
  );
    return base + word_t'(blk * blk_bytes) + word_t'(4 * wrd);
  endfunction

endpackage

// File: rtl/l2_dummy_array.sv
// Block storage for the L2 stand-in: one async read port, one write
// port, asynchronously restored to the address pattern on reset.
module l2_dummy_array
  import bus_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6,
  parameter int          DW        = DATA_WIDTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic [AW-1:0] ridx,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [DW-1:0] wdata
);

  localparam int WORDS = DW / 32;
  localparam int BB    = 4 * WORDS;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < WORDS; j++) begin
          mem[i][32*j +: 32] <= pattern_word(BASE_ADDR, i, j, BB);
        end
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/l2_dummy_mem.sv
// Behavioural L2 behind the bus controller: fixed-latency FSM,
// request latches, range checking and completion counters.
module l2_dummy_mem
  import bus_pkg::*;
#(
  parameter int          BLOCK_SIZE = bus_pkg::BLOCK_SIZE,
  parameter int          LATENCY    = 4,
  parameter int          DEPTH      = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    l2REN,
  input  logic                    l2WEN,
  input  logic [31:0]             l2addr,
  input  logic [32*BLOCK_SIZE-1:0] l2store,
  output logic [32*BLOCK_SIZE-1:0] l2load,
  output l2_state_t               l2state,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count
);

  localparam int DW = 32 * BLOCK_SIZE;
  localparam int BB = 4 * BLOCK_SIZE;
  localparam int LG = $clog2(BB);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [32:0] LO   = {1'b0, BASE_ADDR};
  localparam logic [31:0] SPAN = 32'(DEPTH * BB);

  l2_state_t     state;
  l2_state_t     nxt;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata;

  logic [32:0]   off;
  logic [AW-1:0] idx_d;
  logic          legal;
  logic          one_req;
  logic          no_req;
  logic          commit;

  // A borrow out of the subtraction means the address is below the base.
  assign off     = {1'b0, l2addr} - LO;
  assign idx_d   = AW'(off[31:0] >> LG);
  assign legal   = (l2addr[LG-1:0] == '0)
                 && !off[32]
                 && (off[31:0] < SPAN);
  assign one_req = l2REN ^ l2WEN;
  assign no_req  = !l2REN && !l2WEN;

  always_comb begin
    nxt = state;
    unique case (state)
      L2_FREE: begin
        if (l2REN && l2WEN) begin
          nxt = L2_ERROR;
        end else if (one_req) begin
          nxt = legal ? L2_BUSY : L2_ERROR;
        end
      end
      L2_BUSY: begin
        if (no_req) begin
          nxt = L2_FREE;
        end else if (cnt == '0) begin
          nxt = L2_ACCESS;
        end
      end
      L2_ACCESS: nxt = L2_FREE;
      L2_ERROR: begin
        if (no_req) begin
          nxt = L2_FREE;
        end
      end
      default: nxt = L2_FREE;
    endcase
  end

  assign commit = (state == L2_BUSY) && (nxt == L2_ACCESS);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= L2_FREE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt     <= '0;
      op_wr   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (state == L2_FREE && one_req) begin
        op_wr   <= l2WEN;
        idx_q   <= idx_d;
        wdata_q <= l2store;
      end
      if (state == L2_FREE && nxt == L2_BUSY) begin
        cnt <= CW'(LATENCY - 1);
      end else if (state == L2_BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      l2load   <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit) begin
      if (op_wr) begin
        wr_count <= wr_count + 32'd1;
      end else begin
        l2load   <= rdata;
        rd_count <= rd_count + 32'd1;
      end
    end
  end

  l2_dummy_array #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .DW        (DW),
    .BASE_ADDR (BASE_ADDR)
  ) u_array (
    .clk   (clk),
    .nRST  (nRST),
    .ridx  (idx_q),
    .rdata (rdata),
    .we    (commit && op_wr),
    .widx  (idx_q),
    .wdata (wdata_q)
  );

  assign l2state = state;

endmodule

// File: tb/tb_l2_dummy_mem.sv
// Scenario bench for l2_dummy_mem: a queue of expected ACCESS
// results is drained by a monitor; timing checked inline.
module tb_l2_dummy_mem;
  import bus_pkg::*;

  typedef struct packed {
    logic        rd;
    logic [63:0] d;
  } exp_t;

  logic        clk;
  logic        nRST;
  logic        l2REN;
  logic        l2WEN;
  logic [31:0] l2addr;
  logic [63:0] l2store;
  logic [63:0] l2load;
  l2_state_t   l2state;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int          vec;
  int          err;
  int          exp_rd;
  int          exp_wr;
  exp_t        sb[$];
  logic [63:0] model[64];

  l2_dummy_mem dut (
    .clk      (clk),
    .nRST     (nRST),
    .l2REN    (l2REN),
    .l2WEN    (l2WEN),
    .l2addr   (l2addr),
    .l2store  (l2store),
    .l2load   (l2load),
    .l2state  (l2state),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i);
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = 32'(i * 8);
    w1 = 32'(i * 8 + 4);
    return {w1, w0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = pat(i);
  endtask

  always @(negedge clk) begin
    if (nRST && l2state == L2_ACCESS) begin
      exp_t e;
      vec++;
      if (sb.size() == 0) begin
        err++;
        $display("FAIL sb_unexpected_access: got ACCESS want none");
      end else begin
        e = sb.pop_front();
        if (e.rd && l2load !== e.d) begin
          err++;
          $display("FAIL sb_l2load: got %h want %h", l2load, e.d);
        end
      end
    end
  end

  task automatic req(
    input  logic        r,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [63:0] d,
    output int          busy,
    output bit          ok
  );
    @(negedge clk);
    l2REN = r; l2WEN = w; l2addr = a; l2store = d;
    busy = 0; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (l2state == L2_BUSY) busy++;
      else if (l2state == L2_ACCESS) ok = 1'b1;
    end
    l2REN = 1'b0; l2WEN = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; l2REN = 1'b0; l2WEN = 1'b0;
    l2addr = '0; l2store = '0;
    model_reset();
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    vec++;
    if (l2state !== L2_FREE || l2load !== 64'h0 ||
        rd_count !== 32'd0 || wr_count !== 32'd0) begin
      err++;
      $display("FAIL reset: got st=%0d ld=%h rc=%0d wc=%0d want 0s",
               l2state, l2load, rd_count, wr_count);
    end
  endtask

  task automatic test_read();
    int busy; bit ok;
    sb.push_back('{rd: 1'b1, d: {32'h14, 32'h10}});
    req(1'b1, 1'b0, 32'h10, 64'h0, busy, ok);
    exp_rd++;
    vec++;
    if (!ok || busy != 4) begin
      err++;
      $display("FAIL read_latency: got ok=%0b busy=%0d want 1/4", ok, busy);
    end
    @(negedge clk);
    vec++;
    if (l2state !== L2_FREE || rd_count !== 32'(exp_rd)) begin
      err++;
      $display("FAIL read_after: got st=%0d rc=%0d want 0/%0d",
               l2state, rd_count, exp_rd);
    end
  endtask

  task automatic test_write_read();
    int busy; bit ok;
    sb.push_back('{rd: 1'b0, d: 64'h0});
    req(1'b0, 1'b1, 32'h40, 64'hDEADBEEF_CAFEF00D, busy, ok);
    model[8] = 64'hDEADBEEF_CAFEF00D;
    exp_wr++;
    @(negedge clk);
    vec++;
    if (!ok || busy != 4 || wr_count !== 32'(exp_wr)) begin
      err++;
      $display("FAIL write: got ok=%0b busy=%0d wc=%0d want 1/4/%0d",
               ok, busy, wr_count, exp_wr);
    end
    sb.push_back('{rd: 1'b1, d: model[8]});
    req(1'b1, 1'b0, 32'h40, 64'h0, busy, ok);
    exp_rd++;
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL write_readback: got timeout want ACCESS");
    end
  endtask

  task automatic test_illegal();
    int busy; bit ok;
    @(negedge clk);
    l2WEN = 1'b1; l2addr = 32'h0C; l2store = 64'h1111_2222_3333_4444;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++;
      if (l2state !== L2_ERROR) begin
        err++;
        $display("FAIL misalign_hold: got %0d want %0d", l2state, L2_ERROR);
      end
    end
    l2WEN = 1'b0;
    @(negedge clk);
    vec++;
    if (l2state !== L2_FREE || wr_count !== 32'(exp_wr)) begin
      err++;
      $display("FAIL misalign_release: got st=%0d wc=%0d want 0/%0d",
               l2state, wr_count, exp_wr);
    end
    sb.push_back('{rd: 1'b1, d: model[1]});
    req(1'b1, 1'b0, 32'h08, 64'h0, busy, ok);
    exp_rd++;
    @(negedge clk);
    l2REN = 1'b1; l2WEN = 1'b1; l2addr = 32'h10;
    @(negedge clk);
    vec++;
    if (l2state !== L2_ERROR) begin
      err++;
      $display("FAIL both_req: got %0d want %0d", l2state, L2_ERROR);
    end
    l2REN = 1'b0; l2WEN = 1'b0;
    @(negedge clk);
    vec++;
    if (l2state !== L2_FREE) begin
      err++;
      $display("FAIL both_release: got %0d want %0d", l2state, L2_FREE);
    end
  endtask

  task automatic test_boundary();
    int busy; bit ok;
    sb.push_back('{rd: 1'b1, d: {32'h1FC, 32'h1F8}});
    req(1'b1, 1'b0, 32'h1F8, 64'h0, busy, ok);
    exp_rd++;
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL last_block: got timeout want ACCESS");
    end
    @(negedge clk);
    l2REN = 1'b1; l2addr = 32'h200;
    @(negedge clk);
    vec++;
    if (l2state !== L2_ERROR) begin
      err++;
      $display("FAIL past_end: got %0d want %0d", l2state, L2_ERROR);
    end
    l2REN = 1'b0;
    @(negedge clk);
    vec++;
    if (l2state !== L2_FREE || rd_count !== 32'(exp_rd) ||
        wr_count !== 32'(exp_wr)) begin
      err++;
      $display("FAIL past_end_cnt: got st=%0d rc=%0d wc=%0d want 0/%0d/%0d",
               l2state, rd_count, wr_count, exp_rd, exp_wr);
    end
  endtask

  task automatic test_abort();
    int busy; bit ok;
    @(negedge clk);
    l2WEN = 1'b1; l2addr = 32'h08; l2store = 64'hA5A5_A5A5_5A5A_5A5A;
    @(negedge clk);
    @(negedge clk);
    vec++;
    if (l2state !== L2_BUSY) begin
      err++;
      $display("FAIL abort_busy: got %0d want %0d", l2state, L2_BUSY);
    end
    l2WEN = 1'b0;
    @(negedge clk);
    vec++;
    if (l2state !== L2_FREE || wr_count !== 32'(exp_wr)) begin
      err++;
      $display("FAIL abort_free: got st=%0d wc=%0d want 0/%0d",
               l2state, wr_count, exp_wr);
    end
    sb.push_back('{rd: 1'b1, d: model[1]});
    req(1'b1, 1'b0, 32'h08, 64'h0, busy, ok);
    exp_rd++;
  endtask

  task automatic test_back_to_back();
    int t[2];
    int n;
    n = 0;
    sb.push_back('{rd: 1'b1, d: model[6]});
    sb.push_back('{rd: 1'b1, d: model[7]});
    @(negedge clk);
    l2REN = 1'b1; l2addr = 32'h30;
    for (int c = 1; c <= 40 && n < 2; c++) begin
      @(negedge clk);
      if (c == 1) l2addr = 32'h38;
      if (l2state == L2_ACCESS) begin
        t[n] = c;
        n++;
      end
    end
    l2REN = 1'b0;
    exp_rd += 2;
    vec++;
    if (n != 2 || t[0] != 5 || t[1] != 11) begin
      err++;
      $display("FAIL b2b_timing: got n=%0d t0=%0d t1=%0d want 2/5/11",
               n, t[0], t[1]);
    end
    @(negedge clk);
    vec++;
    if (rd_count !== 32'(exp_rd)) begin
      err++;
      $display("FAIL b2b_count: got %0d want %0d", rd_count, exp_rd);
    end
  endtask

  task automatic test_reset_mid_write();
    int busy; bit ok;
    @(negedge clk);
    l2WEN = 1'b1; l2addr = 32'h20; l2store = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    vec++;
    if (l2state !== L2_FREE || wr_count !== 32'd0 ||
        rd_count !== 32'd0 || l2load !== 64'h0) begin
      err++;
      $display("FAIL mid_reset: got st=%0d rc=%0d wc=%0d ld=%h want 0s",
               l2state, rd_count, wr_count, l2load);
    end
    model_reset();
    exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    l2WEN = 1'b0;
    nRST = 1'b1;
    sb.push_back('{rd: 1'b1, d: {32'h24, 32'h20}});
    req(1'b1, 1'b0, 32'h20, 64'h0, busy, ok);
    exp_rd++;
    @(negedge clk);
    vec++;
    if (!ok || rd_count !== 32'(exp_rd) || wr_count !== 32'd0) begin
      err++;
      $display("FAIL post_reset_read: got ok=%0b rc=%0d wc=%0d want 1/%0d/0",
               ok, rd_count, wr_count, exp_rd);
    end
  endtask

  initial begin
    vec = 0; err = 0; exp_rd = 0; exp_wr = 0;
    test_reset();
    test_read();
    test_write_read();
    test_illegal();
    test_boundary();
    test_abort();
    test_back_to_back();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    vec++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/l2_dummy_mem.md
# l2_dummy_mem

Behavioural L2/main-memory stand-in that sits directly downstream of the coherence bus controller in the bus_ctrl UVM environment. It consumes the controller's L2 request signals (l2REN, l2WEN, l2addr, l2store) and returns block-wide read data and the 2-bit L2 state (FREE, BUSY, ACCESS, ERROR). Latency is fixed and configurable, and storage is an addressable block array. The controller's READ_L2 and WRITEBACK paths are therefore exercised against real storage with deterministic timing.

## Interface
- BLOCK_SIZE, 2: 32-bit words per transfer; DATA_WIDTH = 32*BLOCK_SIZE, BLOCK_BYTES = 4*BLOCK_SIZE
- LATENCY, 4: cycles spent in BUSY per request; legal range ≥ 1
- DEPTH, 64: number of blocks stored
- BASE_ADDR, 32'h0000_0000: byte address of block 0; must be BLOCK_BYTES-aligned
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- nRST  in  1  asynchronous active-low reset
- l2REN  in  1  read request, held until ACCESS
- l2WEN  in  1  write request, held until ACCESS
- l2addr  in  32  byte address of block
- l2store  in  DATA_WIDTH  write data; word j in bits [32j+31:32j]
- l2load  out  DATA_WIDTH  read data, registered
- l2state  out  2  l2_state_t: L2_FREE, L2_BUSY, L2_ACCESS, L2_ERROR
- rd_count  out  32  completed reads
- wr_count  out  32  completed writes

## Operation
- FREE, with exactly one of REN/WEN high:
  - Latch addr, store data and op.
  - A request is illegal if addr[log2(BLOCK_BYTES)-1:0] != 0, addr < BASE_ADDR, or addr ≥ BASE_ADDR + DEPTH*BLOCK_BYTES.
  - Illegal → ERROR. Legal → BUSY, with the counter loaded to LATENCY-1.
- FREE, with REN and WEN both high → ERROR.
- BUSY:
  - If REN and WEN are both low → FREE (abort). No write, no count increment.
  - Else if counter == 0 → ACCESS. Else decrement the counter.
  - Address and data changes during BUSY are ignored; the latched values are used.
- ACCESS entry edge:
  - Read: l2load ← mem[idx], rd_count++.
  - Write: mem[idx] ← latched store, wr_count++.
  - idx = (addr − BASE_ADDR) >> log2(BLOCK_BYTES).
- ACCESS → FREE unconditionally after one cycle.
  - A request still asserted in that FREE cycle is treated as a new request.
- ERROR:
  - Held while REN or WEN is high. Returns to FREE the cycle after both are low.
  - Memory and counters are unchanged.
- l2load holds its last value outside read-ACCESS entry.
- Memory pattern (applied at reset): word j of block i = BASE_ADDR + i*BLOCK_BYTES + 4j, i.e. each word holds its own byte address.
- Counters wrap modulo 2^32.

## Timing
- Reset (async, immediate):
  - l2state=L2_FREE, l2load=0, rd_count=0, wr_count=0, counter=0.
  - Memory restored to the pattern.
  - An in-flight request is discarded; a pending write never commits.
- Request sampled in FREE at edge k:
  - BUSY during cycles k+1 … k+LATENCY.
  - ACCESS during cycle k+LATENCY+1, with l2load valid in that same cycle.
  - FREE at k+LATENCY+2.
- Back-to-back throughput: one request per LATENCY+2 cycles.
- ERROR is visible the cycle after the illegal request is sampled.
- Abort takes effect the cycle after deassertion is sampled in BUSY.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package bus_pkg holds: l2_state_t, BLOCK_SIZE, DATA_WIDTH, word_t, transfer_width_t. These are imported by both the bus controller and this block.
- Sub-module l2_dummy_array holds DEPTH × DATA_WIDTH storage:
  - One read port and one write port.
  - Async reset-to-pattern.
- The top level holds the FSM, the latency counter, the request latches, legality checking and the statistics counters.

## Test plan
Defaults throughout: LATENCY=4, DEPTH=64, BASE_ADDR=0.
- **Read after reset:** REN, addr 0x10 at edge k.
  - Response: BUSY k+1..k+4, ACCESS at k+5.
  - l2load = {32'h14, 32'h10}, rd_count = 1.
- **Write then read:** WEN, addr 0x40, data 64'hDEADBEEF_CAFEF00D, completes in ACCESS.
  - A subsequent read of 0x40 returns 64'hDEADBEEF_CAFEF00D.
  - wr_count = 1.
- **Illegal requests:**
  - Misaligned addr 0x0C → ERROR while held; FREE one cycle after release; mem[1] unchanged.
  - REN+WEN together → ERROR.
- **Range boundary:**
  - addr 0x1F8 reads {32'h1FC, 32'h1F8}.
  - addr 0x200 → ERROR; counters unchanged.
- **Abort:** WEN to 0x08 dropped in the 2nd BUSY cycle.
  - FREE next cycle; mem[1] = {32'hC, 32'h8}; wr_count = 0.
- **Reset mid-write:** nRST low during BUSY of a write to 0x20.
  - l2state = FREE immediately.
  - After release, a read of 0x20 returns {32'h24, 32'h20}.
